// File: rtl/taxi_trip_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : taxi_trip_ctrl
//  Brief    : Taximeter trip sequencer. Runs the IDLE/RUN/WAIT/HALT trip FSM
//             and accumulates the saturating fare, distance and wait minutes.
//  Revision : 1.0  initial release
// ============================================================================
module taxi_trip_ctrl #(
    parameter logic [15:0] BASE_FARE  = 16'd100,
    parameter logic [15:0] BASE_DIST  = 16'd30,
    parameter logic [15:0] UNIT_FARE  = 16'd2,
    parameter logic [15:0] IDLE_SECS  = 16'd10,
    parameter logic [15:0] WAIT_COUNT = 16'd5,
    parameter logic [15:0] WAIT_FARE  = 16'd10,
    parameter logic [15:0] FARE_MAX   = 16'd9999
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        start_key,
    input  logic        stop_key,
    input  logic        dist_pulse,
    input  logic        sec_tick,
    output logic [1:0]  state,
    output logic [15:0] fare,
    output logic [15:0] distance,
    output logic [15:0] wait_min,
    output logic        wait_fare_pulse
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_WAIT = 2'b10,
        S_HALT = 2'b11
    } state_t;

    state_t      state_q;
    logic [15:0] fare_q;
    logic [15:0] distance_q;
    logic [15:0] wait_min_q;
    logic        pulse_q;
    logic [15:0] idle_sec_q;
    logic [5:0]  sec_cnt_q;
    logic [15:0] wait_sub_q;

    logic [15:0] dist_inc_d;
    logic [15:0] fare_dist_d;
    logic [15:0] wait_min_inc_d;
    logic [15:0] fare_wait_d;
    logic        start_trip_d;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, FARE_MAX}) ? FARE_MAX : s[15:0];
    endfunction

    assign dist_inc_d     = sat_add(distance_q, 16'd1);
    assign fare_dist_d    = (dist_inc_d > BASE_DIST) ? sat_add(fare_q, UNIT_FARE) : fare_q;
    assign wait_min_inc_d = sat_add(wait_min_q, 16'd1);
    assign fare_wait_d    = sat_add(fare_q, WAIT_FARE);
    // A trip may only be (re)started from IDLE or HALT, and stop always wins.
    assign start_trip_d   = start_key && !stop_key &&
                            ((state_q == S_IDLE) || (state_q == S_HALT));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fare_q     <= 16'd0;
            distance_q <= 16'd0;
            wait_min_q <= 16'd0;
            pulse_q    <= 1'b0;
            idle_sec_q <= 16'd0;
            sec_cnt_q  <= 6'd0;
            wait_sub_q <= 16'd0;
        end else begin
            pulse_q <= 1'b0;
            if (start_trip_d) begin
                state_q    <= S_RUN;
                fare_q     <= BASE_FARE;
                distance_q <= 16'd0;
                wait_min_q <= 16'd0;
                idle_sec_q <= 16'd0;
                sec_cnt_q  <= 6'd0;
                wait_sub_q <= 16'd0;
            end else begin
                case (state_q)
                    S_RUN: begin
                        if (stop_key) begin
                            state_q <= S_HALT;
                        end else if (dist_pulse) begin
                            distance_q <= dist_inc_d;
                            fare_q     <= fare_dist_d;
                            idle_sec_q <= 16'd0;
                        end else if (sec_tick) begin
                            if (idle_sec_q == IDLE_SECS - 16'd1) begin
                                state_q    <= S_WAIT;
                                idle_sec_q <= 16'd0;
                                sec_cnt_q  <= 6'd0;
                            end else begin
                                idle_sec_q <= idle_sec_q + 16'd1;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (stop_key) begin
                            state_q <= S_HALT;
                        end else if (dist_pulse) begin
                            // Partial minute is discarded; wait_sub carries over.
                            state_q    <= S_RUN;
                            distance_q <= dist_inc_d;
                            fare_q     <= fare_dist_d;
                            idle_sec_q <= 16'd0;
                            sec_cnt_q  <= 6'd0;
                        end else if (sec_tick) begin
                            if (sec_cnt_q == 6'd59) begin
                                sec_cnt_q  <= 6'd0;
                                wait_min_q <= wait_min_inc_d;
                                if (wait_sub_q == WAIT_COUNT - 16'd1) begin
                                    wait_sub_q <= 16'd0;
                                    fare_q     <= fare_wait_d;
                                    pulse_q    <= 1'b1;
                                end else begin
                                    wait_sub_q <= wait_sub_q + 16'd1;
                                end
                            end else begin
                                sec_cnt_q <= sec_cnt_q + 6'd1;
                            end
                        end
                    end
                    S_HALT: begin
                        if (stop_key) begin
                            state_q    <= S_IDLE;
                            fare_q     <= 16'd0;
                            distance_q <= 16'd0;
                            wait_min_q <= 16'd0;
                            idle_sec_q <= 16'd0;
                            sec_cnt_q  <= 6'd0;
                            wait_sub_q <= 16'd0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign state           = state_q;
    assign fare            = fare_q;
    assign distance        = distance_q;
    assign wait_min        = wait_min_q;
    assign wait_fare_pulse = pulse_q;

endmodule
`default_nettype wire

// File: doc/taxi_trip_ctrl.md
# taxi_trip_ctrl

Trip sequencer for the taximeter datapath. It runs the trip state machine (idle, running, waiting, halted) from the start and stop keys, the distance pulses and a one-second tick. It decides when the car counts as waiting, and drives the waiting-minute divider, the per-WAIT_COUNT-minute waiting charge and the distance charge into one registered fare accumulator for the display path. It replaces free-running waiting division with counting gated by trip state.

## Interface
- BASE_FARE, 100: fare loaded at trip start, in units of 0.1 yuan.
- BASE_DIST, 30: distance units (100 m each) included in BASE_FARE.
- UNIT_FARE, 2: charge per distance unit beyond BASE_DIST, in 0.1 yuan.
- IDLE_SECS, 10: seconds without a dist_pulse before RUN enters WAIT.
- WAIT_COUNT, 5: waiting minutes per waiting charge.
- WAIT_FARE, 10: charge per WAIT_COUNT waiting minutes, in 0.1 yuan.
- FARE_MAX, 9999: saturation limit for fare, distance and wait_min.

Ports:
- sys_clk, input, 1: system clock. All logic is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start_key, input, 1: single-cycle, already debounced. Starts a trip.
- stop_key, input, 1: single-cycle, already debounced. Ends or clears a trip.
- dist_pulse, input, 1: single-cycle pulse per 100 m travelled.
- sec_tick, input, 1: single-cycle pulse once per second.
- state, output, 2: IDLE=00, RUN=01, WAIT=10, HALT=11.
- fare, output, 16: accumulated fare in 0.1 yuan, binary.
- distance, output, 16: distance units travelled this trip.
- wait_min, output, 16: whole waiting minutes this trip.
- wait_fare_pulse, output, 1: one-cycle strobe on each waiting charge.

## Operation
- Reset: state=IDLE; fare, distance, wait_min and all internal counters are 0; wait_fare_pulse=0.
- Internal counters:
  - idle_sec, counts up to IDLE_SECS.
  - sec_cnt, counts 0..59.
  - wait_sub, counts 0..WAIT_COUNT-1.
- Per-cycle event priority: stop_key, then start_key, then dist_pulse, then sec_tick.
- IDLE:
  - start_key goes to RUN. Load fare=BASE_FARE and clear distance, wait_min and all internal counters.
  - All other inputs are ignored.
- RUN:
  - dist_pulse: increment distance and clear idle_sec. If the new distance is greater than BASE_DIST, add UNIT_FARE to fare.
  - sec_tick with no dist_pulse: increment idle_sec. When it reaches IDLE_SECS, go to WAIT with idle_sec=0 and sec_cnt=0.
  - stop_key goes to HALT.
- WAIT:
  - sec_tick: increment sec_cnt. At 59 it wraps to 0, wait_min increments and wait_sub increments.
  - When wait_sub wraps from WAIT_COUNT-1 to 0, add WAIT_FARE to fare and pulse wait_fare_pulse.
  - dist_pulse goes to RUN. The distance is charged in that same cycle as in RUN, and sec_cnt clears, so a partial minute is discarded. wait_sub is kept, so waiting accumulates across the whole trip.
  - stop_key goes to HALT.
- HALT:
  - All outputs are frozen for display.
  - start_key starts a new trip, with the same loads as from IDLE.
  - stop_key goes to IDLE and clears everything.
  - dist_pulse and sec_tick are ignored.
- start_key in RUN or WAIT is ignored.
- Arithmetic:
  - Every addition saturates at FARE_MAX and never wraps.
  - distance and wait_min also saturate at FARE_MAX.
  - Counters keep running while the fare is saturated.

## Timing
- All outputs are registered. They reflect an input event on the first rising edge that samples it, so latency is one cycle.
- wait_fare_pulse is high for exactly the one cycle after the edge that samples the sec_tick completing the WAIT_COUNT-th minute. Its fare update is visible in the same cycle.
- A dist_pulse and a sec_tick in the same RUN cycle: the distance is counted, idle_sec=0 and there is no WAIT entry.
- A dist_pulse and a sec_tick in the same WAIT cycle: go to RUN, and the tick is dropped.
- A stop_key that coincides with any event: only the HALT transition happens and no charge is applied.
- A start_key and a stop_key in the same cycle: stop wins.
- rst_n low at any time, including mid-trip: outputs go to their reset values immediately (asynchronously) and stay there until the first edge after rst_n is released.
- There is no back-pressure. Inputs arriving faster than one per cycle are not supported.

## Test plan
1. Reset and start:
   - Hold rst_n low, release, pulse start_key.
   - Required: state=01, fare=100, distance=0.
2. Distance charge:
   - Apply 35 dist_pulses.
   - Required: distance=35, fare=110. Pulses 31 to 35 each add 2.
3. Waiting entry and charge:
   - From RUN, apply 10 sec_ticks with no dist_pulse.
   - Required: state=10 after the 10th tick.
   - Then apply 300 sec_ticks.
   - Required: wait_min=5, exactly one wait_fare_pulse, fare increased by 10.
4. Leaving WAIT mid-minute:
   - Apply 30 sec_ticks in WAIT, then a dist_pulse, then 10 idle ticks, then 60 ticks.
   - Required: wait_min increments only after the 60 ticks, and no charge occurs.
5. Stop, halt, start and clear:
   - Pulse stop_key.
   - Required: state=11, values frozen, further ticks have no effect.
   - Pulse start_key.
   - Required: fare=100, distance=0.
   - Pulse stop_key twice.
   - Required: state=00, all outputs zero.
6. Saturation and mid-trip reset:
   - Apply enough dist_pulses to push fare past 9999.
   - Required: fare holds at 9999.
   - Pulse rst_n low for 3 ns mid-trip.
   - Required: all outputs are 0 immediately and state=00.
